// File: rtl/tc0480scp_rom_arbiter.sv
// rtl/tc0480scp_rom_arbiter.sv - round-robin arbiter sharing the 64-bit graphics ROM port among BG0..BG3 fetchers
`timescale 1ns/1ps
module tc0480scp_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rsp_done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_address,
  output logic                      rom_req,
  input  logic                      rom_ack,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [NUM_REQ-1:0] eligible;
  logic [ADDR_W-1:0]  pick_addr;
  logic               discard;
  logic               drop_rsp;

  // Round-robin search: first eligible requester at or above ptr, wrapping.
  // Index arithmetic wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    eligible = flush ? '0 : req_valid;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && eligible[ptr + IDX_W'(k)]) begin
        pick     = ptr + IDX_W'(k);
        pick_vld = 1'b1;
      end
    end
  end

  // Address mux for the chosen requester.
  always_comb begin
    pick_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == IDX_W'(k)) begin
        pick_addr = req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // A completion is swallowed if a flush happened during WAIT or arrives with the ack.
  assign drop_rsp = discard | flush;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE always spends exactly one cycle without arbitrating.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = WAIT;
      WAIT:    if (rom_ack)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, ROM handshake, response return and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      idx         <= '0;
      discard     <= 1'b0;
      rom_req     <= 1'b0;
      rom_address <= '0;
      rsp_done    <= '0;
      rsp_data    <= '0;
    end else begin
      rsp_done <= '0;
      if (flush) begin
        ptr <= '0;
      end
      case (state)
        IDLE: begin
          if (pick_vld) begin
            idx         <= pick;
            rom_address <= pick_addr;
            rom_req     <= 1'b1;
          end
        end
        WAIT: begin
          if (flush) begin
            discard <= 1'b1;
          end
          if (rom_ack) begin
            rom_req  <= 1'b0;
            rsp_data <= rom_data;
            discard  <= 1'b0;
            if (drop_rsp) begin
              // An abandoned fetch does not advance fairness; restart from BG0.
              ptr <= '0;
            end else begin
              rsp_done[idx] <= 1'b1;
              ptr           <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tc0480scp_rom_arbiter.sv
// tb/tb_tc0480scp_rom_arbiter.sv - scoreboard bench for tc0480scp_rom_arbiter
`timescale 1ns/1ps
module tb_tc0480scp_rom_arbiter;

  localparam int NR = 4;
  localparam int AW = 21;
  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    rsp_done;
  logic [DW-1:0]    rsp_data;
  logic [AW-1:0]    rom_address;
  logic             rom_req;
  logic             rom_ack;
  logic [DW-1:0]    rom_data;
  logic             busy;

  tc0480scp_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr),
    .rsp_done(rsp_done), .rsp_data(rsp_data),
    .rom_address(rom_address), .rom_req(rom_req),
    .rom_ack(rom_ack), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] done;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  int            gq[$];
  rsp_t          rq[$];
  logic [AW-1:0] addr_tab [NR];
  logic [DW-1:0] data_tab [NR];

  int            n_pass = 0;
  int            n_chk = 0;
  int            cyc = 0;
  bit            auto_ack = 0;
  bit            auto_drop = 0;
  int            lat = 1;
  int            wait_cnt = 0;
  int            cur_exp = 0;
  int            low_cnt = 0;
  int            stop_after = 0;
  int            done_cnt = 0;
  bit            prev_req = 0;
  bit            had_txn = 0;
  logic [NR-1:0] drop_next = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic monitor();
    rsp_t e;
    cyc++;
    rom_ack   = 1'b0;
    req_valid = req_valid & ~drop_next;
    drop_next = '0;
    if (reset) begin
      prev_req = 0;
      low_cnt  = 0;
      had_txn  = 0;
      return;
    end
    if (rom_req && !prev_req) begin
      if (had_txn) chk("gap", 64'(low_cnt >= 2), 1);
      had_txn = 1;
      if (gq.size() == 0) begin
        chk("grant_extra", 1, 0);
      end else begin
        cur_exp = gq.pop_front();
        chk("grant_addr", rom_address, addr_tab[cur_exp]);
      end
      wait_cnt = 0;
    end
    if (rom_req) low_cnt = 0;
    else low_cnt++;
    if (rsp_done != '0) begin
      if (rq.size() == 0) begin
        chk("done_extra", rsp_done, 0);
      end else begin
        e = rq.pop_front();
        chk("done_idx", rsp_done, e.done);
        chk("done_data", rsp_data, e.data);
        chk("done_cycle", cyc, e.due);
      end
      if (auto_drop) drop_next = rsp_done;
      done_cnt++;
      if (done_cnt == stop_after) req_valid = '0;
    end
    if (rom_req && auto_ack) begin
      wait_cnt++;
      if (wait_cnt == lat) begin
        rom_ack  = 1'b1;
        rom_data = data_tab[cur_exp];
        e.done   = NR'(1 << cur_exp);
        e.data   = data_tab[cur_exp];
        e.due    = cyc + 1;
        rq.push_back(e);
      end
    end
    prev_req = rom_req;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    flush      = 1'b0;
    req_valid  = '0;
    rom_ack    = 1'b0;
    auto_ack   = 0;
    auto_drop  = 0;
    stop_after = 0;
    done_cnt   = 0;
    drop_next  = '0;
    gq.delete();
    rq.delete();
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((gq.size() != 0 || rq.size() != 0 || busy || rom_req) && n < budget) begin
      step();
      n++;
    end
    chk("timeout", 64'(n < budget), 1);
    repeat (6) step();
    chk("idle_busy", busy, 0);
    chk("queues_empty", gq.size() + rq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    addr_tab[0] = 21'h00100;
    addr_tab[1] = 21'h0ABCD;
    addr_tab[2] = 21'h12345;
    addr_tab[3] = 21'h1FFFF;
    data_tab[0] = 64'h0123_4567_89AB_CDEF;
    data_tab[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    data_tab[2] = 64'hDEADBEEF_CAFEF00D;
    data_tab[3] = 64'hFFFF_0000_1234_8765;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = addr_tab[i];
    rom_data = '0;

    // Reset values
    do_reset();
    chk("rst_rom_req", rom_req, 0);
    chk("rst_rom_address", rom_address, 0);
    chk("rst_rsp_done", rsp_done, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);

    // Single request from BG2, ack 5 cycles after rom_req
    auto_ack  = 1;
    lat       = 5;
    auto_drop = 1;
    gq.push_back(2);
    req_valid = 4'b0100;
    step();
    chk("req_latency", rom_req, 1);
    chk("busy_wait", busy, 1);
    wait_idle(60);
    chk("rsp_hold", rsp_data, 64'hDEADBEEF_CAFEF00D);

    // Round robin over all four
    do_reset();
    auto_ack  = 1;
    lat       = 3;
    auto_drop = 1;
    for (int i = 0; i < NR; i++) gq.push_back(i);
    req_valid = 4'b1111;
    wait_idle(200);

    // Fairness: BG0 and BG2 held continuously
    do_reset();
    auto_ack   = 1;
    lat        = 2;
    stop_after = 8;
    for (int i = 0; i < 4; i++) begin
      gq.push_back(0);
      gq.push_back(2);
    end
    req_valid = 4'b0101;
    wait_idle(300);

    // Flush two cycles before the ack in WAIT
    do_reset();
    gq.push_back(1);
    req_valid = 4'b0010;
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    rom_ack   = 1'b1;
    rom_data  = 64'h1111_2222_3333_4444;
    req_valid = 4'b1001;
    step();
    chk("flush_req_fall", rom_req, 0);
    chk("flush_no_done", rsp_done, 0);
    chk("flush_data", rsp_data, 64'h1111_2222_3333_4444);
    gq.push_back(0);
    gq.push_back(3);
    auto_ack  = 1;
    lat       = 2;
    auto_drop = 1;
    wait_idle(100);

    // Flush in IDLE concurrent with a request
    do_reset();
    gq.push_back(0);
    req_valid = 4'b0001;
    flush     = 1'b1;
    step();
    chk("flush_idle_block", rom_req, 0);
    flush = 1'b0;
    step();
    chk("flush_idle_grant", rom_req, 1);
    auto_ack  = 1;
    lat       = 1;
    auto_drop = 1;
    wait_idle(50);

    // Reset mid-transaction followed by a spurious ack
    do_reset();
    gq.push_back(2);
    req_valid = 4'b0100;
    step();
    chk("rst_mid_req_hi", rom_req, 1);
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_req_low", rom_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", rom_address, 0);
    reset     = 1'b0;
    req_valid = '0;
    step();
    step();
    rom_ack  = 1'b1;
    rom_data = 64'h5555_6666_7777_8888;
    step();
    step();
    step();
    chk("spur_data", rsp_data, 0);
    chk("spur_req", rom_req, 0);
    chk("spur_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
